// File: rtl/cpu_ex_div_ctl.sv
// Multi-cycle RV32M divide sequencer for the EX stage: radix-2 restoring divider
// with zero-divisor / signed-overflow shortcuts and sign fixup on completion.
module cpu_ex_div_ctl #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            stall_async_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state, w_stateNext;
  logic [CW-1:0]   r_cnt, w_cntNext;
  logic [1:0]      r_op, w_opNext;
  logic            r_negQ, w_negQNext;
  logic            r_negR, w_negRNext;
  logic [XLEN-1:0] r_rem, w_remNext;
  logic [XLEN-1:0] r_quo, w_quoNext;
  logic [XLEN-1:0] r_dvsr, w_dvsrNext;
  logic [XLEN-1:0] r_result, w_resultNext;

  logic            w_signedOp, w_aNeg, w_bNeg, w_isOvf, w_ge;
  logic [XLEN-1:0] w_aAbs, w_bAbs, w_quoStep, w_remStep, w_fixed;
  logic [XLEN:0]   w_remSh, w_sub;

  assign w_signedOp = ~op_i[0];
  assign w_aNeg     = w_signedOp & dividend_i[XLEN-1];
  assign w_bNeg     = w_signedOp & divisor_i[XLEN-1];
  assign w_aAbs     = w_aNeg ? (~dividend_i + 1'b1) : dividend_i;
  assign w_bAbs     = w_bNeg ? (~divisor_i + 1'b1) : divisor_i;
  assign w_isOvf    = w_signedOp && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (divisor_i == {XLEN{1'b1}});

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor on XLEN+1 bits.
  assign w_remSh   = {r_rem, r_quo[XLEN-1]};
  assign w_sub     = w_remSh - {1'b0, r_dvsr};
  assign w_ge      = (w_remSh >= {1'b0, r_dvsr});
  assign w_quoStep = {r_quo[XLEN-2:0], w_ge};
  assign w_remStep = w_ge ? w_sub[XLEN-1:0] : w_remSh[XLEN-1:0];

  always_comb begin
    w_fixed = w_quoStep;
    if (r_op[1]) begin
      w_fixed = r_negR ? (~w_remStep + 1'b1) : w_remStep;
    end else begin
      w_fixed = r_negQ ? (~w_quoStep + 1'b1) : w_quoStep;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    w_opNext     = r_op;
    w_negQNext   = r_negQ;
    w_negRNext   = r_negR;
    w_remNext    = r_rem;
    w_quoNext    = r_quo;
    w_dvsrNext   = r_dvsr;
    w_resultNext = r_result;
    case (r_state)
      IDLE: begin
        if (!flush_i && start_i) begin
          w_opNext   = op_i;
          w_negQNext = w_aNeg ^ w_bNeg;
          w_negRNext = w_aNeg;
          w_dvsrNext = w_bAbs;
          if (divisor_i == '0) begin
            w_resultNext = op_i[1] ? dividend_i : {XLEN{1'b1}};
            w_stateNext  = DONE;
          end else if (w_isOvf) begin
            w_resultNext = op_i[1] ? '0 : dividend_i;
            w_stateNext  = DONE;
          end else begin
            w_remNext   = '0;
            w_quoNext   = w_aAbs;
            w_cntNext   = CW'(XLEN - 1);
            w_stateNext = RUN;
          end
        end
      end
      RUN: begin
        if (flush_i) begin
          w_stateNext = IDLE;
        end else begin
          w_remNext = w_remStep;
          w_quoNext = w_quoStep;
          if (r_cnt == '0) begin
            w_resultNext = w_fixed;
            w_stateNext  = DONE;
          end else begin
            w_cntNext = r_cnt - CW'(1);
          end
        end
      end
      // The start_i still high here belongs to the instruction now leaving EX.
      DONE: w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_negQ   <= 1'b0;
      r_negR   <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_stateNext;
      r_cnt    <= w_cntNext;
      r_op     <= w_opNext;
      r_negQ   <= w_negQNext;
      r_negR   <= w_negRNext;
      r_rem    <= w_remNext;
      r_quo    <= w_quoNext;
      r_dvsr   <= w_dvsrNext;
      r_result <= w_resultNext;
    end
  end

  assign stall_async_o = ((r_state == IDLE) && start_i && !flush_i) || (r_state == RUN);
  assign busy_o        = (r_state == RUN);
  assign done_o        = (r_state == DONE);
  assign result_o      = r_result;

endmodule

// File: tb/tb_cpu_ex_div_ctl.sv
// Scoreboard bench for cpu_ex_div_ctl: a reference divide model queues expected
// results when a divide is issued and a done_o monitor pops and compares them.
module tb_cpu_ex_div_ctl;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expEntry_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic        stall_async_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  int          checkCount = 0;
  int          failCount = 0;
  int          cycleCnt = 0;
  int          doneCycles[$];
  expEntry_t   expQ[$];
  logic [31:0] lastExp = '0;

  cpu_ex_div_ctl #(.XLEN(32)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .op_i(op_i),
    .dividend_i(dividend_i),
    .divisor_i(divisor_i),
    .flush_i(flush_i),
    .stall_async_o(stall_async_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycleCnt++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return $signed(a) / $signed(b);
      2'd1:    return a / b;
      2'd2:    return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  function automatic bit isSpecial(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Completion monitor: every done_o pulse must match the oldest queued expectation.
  always @(negedge clk_i) begin
    expEntry_t e;
    if (done_o) begin
      doneCycles.push_back(cycleCnt);
      if (expQ.size() == 0) begin
        checkOutput("spuriousDone", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput(e.tag, result_o, e.value);
      end
      if (busy_o) checkOutput("doneBusyOverlap", 32'(busy_o), 32'd0);
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int          expLat;
    int          cycles;
    bit          stallOk;
    bit          gotDone;
    exp     = refModel(op, a, b);
    expLat  = isSpecial(op, a, b) ? 1 : 33;
    lastExp = exp;
    expQ.push_back('{tag, exp});
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    cycles  = 0;
    stallOk = 1'b1;
    gotDone = 1'b0;
    while (!gotDone && cycles < 100) begin
      @(negedge clk_i);
      if (done_o) begin
        gotDone = 1'b1;
      end else begin
        if (stall_async_o !== 1'b1) stallOk = 1'b0;
        @(posedge clk_i);
        cycles++;
      end
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, "_stallHeld"}, 32'(stallOk), 32'd1);
    checkOutput({tag, "_stallInDone"}, 32'(stall_async_o), 32'd0);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout cycles=%0d", cycleCnt);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int spacing;
    reset_n_i  = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    op_i       = 2'd0;
    dividend_i = '0;
    divisor_i  = '0;
    #12;
    checkOutput("resetBusy", 32'(busy_o), 32'd0);
    checkOutput("resetDone", 32'(done_o), 32'd0);
    checkOutput("resetResult", result_o, 32'd0);
    checkOutput("resetStall", 32'(stall_async_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    applyStimulus(2'd1, 32'd100, 32'd7, "divu100_7");
    applyStimulus(2'd3, 32'd100, 32'd7, "remu100_7");
    applyStimulus(2'd0, -32'sd7, 32'd2, "divNeg7_2");
    applyStimulus(2'd2, -32'sd7, 32'd2, "remNeg7_2");
    applyStimulus(2'd2, 32'd7, -32'sd2, "rem7_neg2");
    applyStimulus(2'd0, 32'h8000_0000, 32'd2, "divMin_2");

    // Flush on the 10th RUN cycle: no completion, result_o untouched.
    op_i = 2'd1; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i);
    repeat (9) @(posedge clk_i);
    #1;
    checkOutput("preFlushBusy", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flushBusy", 32'(busy_o), 32'd0);
    checkOutput("flushStall", 32'(stall_async_o), 32'd0);
    checkOutput("flushResultHeld", result_o, lastExp);
    repeat (40) @(posedge clk_i);
    #1;
    applyStimulus(2'd1, 32'd9, 32'd3, "divu9_3");

    // Asynchronous reset mid-RUN, away from any clock edge.
    op_i = 2'd1; dividend_i = 32'hFFFF_FFFF; divisor_i = 32'd5; start_i = 1'b1;
    repeat (5) @(posedge clk_i);
    #3;
    reset_n_i = 1'b0;
    start_i   = 1'b0;
    #1;
    checkOutput("asyncRstBusy", 32'(busy_o), 32'd0);
    checkOutput("asyncRstDone", 32'(done_o), 32'd0);
    checkOutput("asyncRstResult", result_o, 32'd0);
    checkOutput("asyncRstStall", 32'(stall_async_o), 32'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    applyStimulus(2'd0, 32'd5, 32'd0, "div5_0");
    applyStimulus(2'd3, 32'd5, 32'd0, "remu5_0");
    applyStimulus(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "divOvf");
    applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "remOvf");

    doneCycles.delete();
    applyStimulus(2'd1, 32'd1234567, 32'd89, "b2bFirst");
    applyStimulus(2'd1, 32'hDEAD_BEEF, 32'd17, "b2bSecond");
    checkOutput("b2bPulseCount", 32'(doneCycles.size()), 32'd2);
    spacing = (doneCycles.size() >= 2) ? (doneCycles[1] - doneCycles[0]) : -1;
    checkOutput("b2bSpacing", 32'(spacing), 32'd34);

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  rOp;
      logic [31:0] rA, rB;
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 3 == 1) rA = -rA;
      applyStimulus(rOp, rA, rB, $sformatf("rand%0d", i));
    end

    repeat (3) @(posedge clk_i);
    checkOutput("queueDrained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
